// File: rtl/adc_scan_sequencer_if.sv
// Sequencer-side bundle: ADC conversion control plus the tagged result handshake.
// The master is the scan sequencer; the slave is the ADC wrapper and result consumer.
interface adc_scan_if #(
    parameter int WIDTH = 8,
    parameter int CH_W  = 2
);
    logic [CH_W-1:0]  mux_sel;
    logic             adc_start;
    logic             adc_done;
    logic [WIDTH-1:0] adc_code;
    logic             res_valid;
    logic             res_ready;
    logic [CH_W-1:0]  res_ch;
    logic [WIDTH-1:0] res_data;

    modport master (
        output mux_sel, adc_start,
        input  adc_done, adc_code,
        output res_valid, res_ch, res_data,
        input  res_ready
    );

    modport slave (
        input  mux_sel, adc_start,
        output adc_done, adc_code,
        input  res_valid, res_ch, res_data,
        output res_ready
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Scans enabled mux channels, settles, averages 2^AVG_LOG2 SAR codes per channel
// and hands out one tagged result per channel over valid/ready.
module adc_scan_sequencer #(
    parameter int WIDTH             = 8,
    parameter int NUM_CH            = 4,
    parameter int MUX_SETTLE_CYCLES = 1000,
    parameter int AVG_LOG2          = 2,
    parameter int TIMEOUT_CYCLES    = 200000,
    parameter int CH_W              = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    adc_scan_if.master        bus,
    output logic              scan_done,
    output logic              busy,
    output logic              conv_timeout
);
    localparam int PTR_W   = CH_W + 1;
    localparam int ACC_W   = WIDTH + AVG_LOG2;
    localparam int SMP_W   = AVG_LOG2 + 1;
    localparam int CNT_MAX = (MUX_SETTLE_CYCLES > TIMEOUT_CYCLES) ? MUX_SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SMP_W-1:0] NSAMP      = SMP_W'(1 << AVG_LOG2);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(MUX_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_OUTPUT = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [NUM_CH-1:0] scan_mask_q, scan_mask_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CH_W-1:0]   mux_sel_q, mux_sel_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [SMP_W-1:0]  samp_q, samp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  res_data_q, res_data_d;
    logic              scan_done_q, scan_done_d;
    logic              timeout_q, timeout_d;

    logic              sel_found;
    logic [CH_W-1:0]   sel_ch;
    logic [ACC_W-1:0]  acc_sum;
    logic [SMP_W-1:0]  samp_inc;
    logic [PTR_W-1:0]  ch_next;

    // Descending walk so the lowest qualifying channel is the one left standing.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (scan_mask_q[i] && (PTR_W'(i) >= ptr_q)) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(i);
            end
        end
    end

    assign acc_sum  = acc_q + ACC_W'(bus.adc_code);
    assign samp_inc = samp_q + SMP_W'(1);
    assign ch_next  = {1'b0, mux_sel_q} + PTR_W'(1);

    always_comb begin
        state_d     = state_q;
        scan_mask_d = scan_mask_q;
        ptr_d       = ptr_q;
        mux_sel_d   = mux_sel_q;
        acc_d       = acc_q;
        samp_d      = samp_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        scan_done_d = 1'b0;
        timeout_d   = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable && (ch_mask != '0)) begin
                    scan_mask_d = ch_mask;
                    ptr_d       = '0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (sel_found) begin
                    mux_sel_d = sel_ch;
                    acc_d     = '0;
                    samp_d    = '0;
                    cnt_d     = SETTLE_LD;
                    state_d   = S_SETTLE;
                end else begin
                    scan_done_d = 1'b1;
                    if (enable && (ch_mask != '0)) begin
                        scan_mask_d = ch_mask;
                        ptr_d       = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_START: begin
                cnt_d   = TIMEOUT_LD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the expiry cycle wins over the timeout.
                if (bus.adc_done) begin
                    acc_d  = acc_sum;
                    samp_d = samp_inc;
                    if (samp_inc == NSAMP) begin
                        res_data_d = WIDTH'(acc_sum >> AVG_LOG2);
                        state_d    = S_OUTPUT;
                    end else begin
                        state_d = S_START;
                    end
                end else if (cnt_q == '0) begin
                    timeout_d = 1'b1;
                    ptr_d     = ch_next;
                    state_d   = enable ? S_SELECT : S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_OUTPUT: begin
                if (bus.res_ready) begin
                    ptr_d   = ch_next;
                    state_d = enable ? S_SELECT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            scan_mask_q <= '0;
            ptr_q       <= '0;
            mux_sel_q   <= '0;
            acc_q       <= '0;
            samp_q      <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            scan_done_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_mask_q <= scan_mask_d;
            ptr_q       <= ptr_d;
            mux_sel_q   <= mux_sel_d;
            acc_q       <= acc_d;
            samp_q      <= samp_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            scan_done_q <= scan_done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.mux_sel   = mux_sel_q;
    assign bus.adc_start = (state_q == S_START);
    assign bus.res_valid = (state_q == S_OUTPUT);
    assign bus.res_ch    = mux_sel_q;
    assign bus.res_data  = res_data_q;
    assign scan_done     = scan_done_q;
    assign busy          = (state_q != S_IDLE);
    assign conv_timeout  = timeout_q;
endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Multi-channel scan controller that sequences the R-2R SAR ADC across an external analog input mux.
- Per channel it selects the mux input, waits for the mux to settle, and issues conversion starts.
- It averages 2^AVG_LOG2 SAR codes and delivers one tagged result per channel over a valid/ready interface.
- It sits between the SAR ADC wrapper and the downstream result consumer (display/UART logic).

Parameters:
- WIDTH, 8, SAR code width; must match the ADC RAMP_WIDTH.
- NUM_CH, 4, number of mux channels (2..16).
- MUX_SETTLE_CYCLES, 1000, cycles waited after each mux_sel change (>=1).
- AVG_LOG2, 2, log2 of samples averaged per channel (0..4).
- TIMEOUT_CYCLES, 200000, max cycles from adc_start to adc_done before abort.
- CH_W is derived: $clog2(NUM_CH), minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; high = scan continuously.
- ch_mask  in  NUM_CH  bit i = include channel i in scan.
- mux_sel  out  CH_W  analog mux channel select.
- adc_start  out  1  one-cycle conversion start pulse to ADC.
- adc_done  in  1  ADC conversion complete; adc_code valid this cycle.
- adc_code  in  WIDTH  ADC result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_ch  out  CH_W  channel of result.
- res_data  out  WIDTH  averaged result.
- scan_done  out  1  one-cycle pulse after last enabled channel of a scan.
- busy  out  1  high in every state except IDLE.
- conv_timeout  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values (synchronous, active-high): state=IDLE; all outputs and internal counters/accumulator 0; latched mask 0.
- IDLE:
  - If enable=1 and ch_mask!=0: latch ch_mask into scan_mask, set next-channel pointer to 0, go SELECT.
  - If enable=1 and ch_mask=0: stay in IDLE, busy=0.
- SELECT (1 cycle):
  - Pick the lowest-index set bit of scan_mask at or above the pointer; register it into mux_sel; clear the accumulator and sample count; go SETTLE.
  - If no set bit remains: pulse scan_done for 1 cycle, then go IDLE if enable=0, else re-latch ch_mask and repeat SELECT from channel 0. A re-latched mask of 0 goes to IDLE.
- SETTLE: count exactly MUX_SETTLE_CYCLES cycles, then go START. mux_sel is stable throughout.
- START: adc_start=1 for exactly this cycle; load the timeout counter; go WAIT_CONV.
- WAIT_CONV:
  - adc_done is ignored in START and sampled only here.
  - On adc_done=1: acc += adc_code (acc is WIDTH+AVG_LOG2 bits, cannot overflow); sample count increments.
    - If count reaches 2^AVG_LOG2: go OUTPUT.
    - Otherwise go START directly; no re-settle within the same channel.
  - If TIMEOUT_CYCLES elapse without adc_done: set conv_timeout; discard the channel (no result); pointer = channel+1; go SELECT.
- OUTPUT:
  - res_data = acc >> AVG_LOG2 (truncating); res_ch = mux_sel; res_valid=1.
  - res_valid, res_data and res_ch are held stable until the cycle with res_ready=1.
  - Transfer occurs on the cycle where res_valid and res_ready are both 1. Next cycle: res_valid=0, pointer = channel+1, go SELECT.
  - res_ready while res_valid=0 has no effect.
- Mask and enable handling:
  - ch_mask changes mid-scan take effect only at the next scan latch.
  - enable dropping mid-scan: the current channel completes (including the OUTPUT handshake); the sequencer then goes IDLE without pulsing scan_done.
- Latency with AVG_LOG2=0 and an ADC done in D cycles:
  - enable rise to adc_start = 2 + MUX_SETTLE_CYCLES cycles.
  - adc_done to res_valid = 1 cycle.
- Simultaneous events:
  - adc_done on the same cycle the timeout expires counts as done (no timeout).
  - reset overrides everything, mid-conversion or mid-handshake; a pending result is dropped.
- Boundary cases:
  - A single-channel mask scans that channel repeatedly, with mux settle each scan.
  - Channel NUM_CH-1 as the last set bit ends the scan.

Test Plan (bench overrides: NUM_CH=4, AVG_LOG2=2, MUX_SETTLE_CYCLES=4, TIMEOUT_CYCLES=64; ADC model returns done 10 cycles after start):
- Mask 4'b0101, codes ch0={10,11,12,13}, ch2={200,201,202,255}, res_ready=1 -> results (ch0,11) then (ch2,214), then scan_done pulse; mux_sel is 0 then 2; 4 adc_start pulses per channel; exactly 4 settle cycles before each channel's first start.
- Mask 4'b0001, enable high for 2 scans, res_ready held 0 for 20 cycles on the first result -> res_valid/res_data/res_ch stable all 20 cycles; the second scan starts only after acceptance.
- Mask 4'b0000, enable=1 -> busy=0, adc_start never pulses.
- Mask 4'b1001, ADC model never answers on ch0 -> after 64 cycles conv_timeout=1; no ch0 result; ch3 result delivered; conv_timeout stays 1 until reset.
- enable dropped during ch0 of mask 4'b0011 -> ch0 result delivered, ch1 not sampled, no scan_done, state IDLE, busy=0.
- reset asserted while in WAIT_CONV and again while res_valid=1 -> next cycle all outputs 0, state IDLE; a fresh enable restarts from channel 0.
